// File: rtl/muldiv.sv
// Iterative multiply/divide unit: restoring DIV (16/8, one quotient bit per clock)
// and shift-add MUL (8x8). Optional macro MULDIV_FAST_OVERFLOW_EN short-cuts DIV overflow.
module muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [3:0]  flags,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state_reg, state_next;
  logic        op_reg, op_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [7:0]  rem_reg, rem_next;
  logic [15:0] quot_reg, quot_next;
  logic [15:0] acc_reg, acc_next;
  logic [15:0] dvd_reg, dvd_next;
  logic [7:0]  dsr_reg, dsr_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        dz_reg, dz_next;
  logic [15:0] result_reg, result_next;
  logic [3:0]  flags_reg, flags_next;

  logic [8:0]  div_shift, div_diff;
  logic        div_ge;
  logic [7:0]  div_rem;
  logic [15:0] div_quot, mul_acc;
  logic        last_iter;

  // 9-bit partial remainder; bit 8 set means it already exceeds any 8-bit divisor,
  // otherwise the borrow out of the subtraction decides the quotient bit.
  assign div_shift = {rem_reg, quot_reg[15]};
  assign div_diff  = div_shift - {1'b0, dsr_reg};
  assign div_ge    = div_shift[8] | ~div_diff[8];
  assign div_rem   = div_ge ? div_diff[7:0] : div_shift[7:0];
  assign div_quot  = {quot_reg[14:0], div_ge};
  assign mul_acc   = dsr_reg[0] ? acc_reg + quot_reg : acc_reg;
  assign last_iter = op_reg ? (cnt_reg == 4'd7) : (cnt_reg == 4'd15);

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    cnt_next    = cnt_reg;
    rem_next    = rem_reg;
    quot_next   = quot_reg;
    acc_next    = acc_reg;
    dvd_next    = dvd_reg;
    dsr_next    = dsr_reg;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    dz_next     = 1'b0;
    result_next = result_reg;
    flags_next  = flags_reg;

    case (state_reg)
      RUN: begin
        busy_next = 1'b1;
        cnt_next  = cnt_reg + 4'd1;
        if (op_reg) begin
          acc_next  = mul_acc;
          quot_next = {quot_reg[14:0], 1'b0};
          dsr_next  = {1'b0, dsr_reg[7:1]};
        end else begin
          rem_next  = div_rem;
          quot_next = div_quot;
        end
        if (last_iter) begin
          state_next = FIN;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          if (op_reg) begin
            result_next = mul_acc;
            flags_next  = {mul_acc[15], 2'b00, mul_acc == 16'h0000};
          end else if (div_quot[15:8] != 8'h00) begin
            result_next = dvd_reg;
            flags_next  = 4'b0100;
          end else begin
            result_next = {div_rem, div_quot[7:0]};
            flags_next  = {div_quot[7], 2'b00, div_quot[7:0] == 8'h00};
          end
        end
      end
      default: begin
        // IDLE and FIN both accept a new launch; FIN falls back to IDLE otherwise.
        state_next = IDLE;
        if (start) begin
          op_next   = op;
          dvd_next  = dividend;
          dsr_next  = divisor;
          cnt_next  = 4'd0;
          rem_next  = 8'h00;
          acc_next  = 16'h0000;
          quot_next = op ? {8'h00, dividend[7:0]} : dividend;
          if (!op && divisor == 8'h00) begin
            state_next  = FIN;
            done_next   = 1'b1;
            dz_next     = 1'b1;
            result_next = dividend;
            flags_next  = 4'b1100;
`ifdef MULDIV_FAST_OVERFLOW_EN
          end else if (!op && dividend[15:8] >= divisor) begin
            state_next  = FIN;
            done_next   = 1'b1;
            result_next = dividend;
            flags_next  = 4'b0100;
`endif
          end else begin
            state_next = RUN;
            busy_next  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      op_reg     <= 1'b0;
      cnt_reg    <= 4'd0;
      rem_reg    <= 8'h00;
      quot_reg   <= 16'h0000;
      acc_reg    <= 16'h0000;
      dvd_reg    <= 16'h0000;
      dsr_reg    <= 8'h00;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dz_reg     <= 1'b0;
      result_reg <= 16'h0000;
      flags_reg  <= 4'h0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      cnt_reg    <= cnt_next;
      rem_reg    <= rem_next;
      quot_reg   <= quot_next;
      acc_reg    <= acc_next;
      dvd_reg    <= dvd_next;
      dsr_reg    <= dsr_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      dz_reg     <= dz_next;
      result_reg <= result_next;
      flags_reg  <= flags_next;
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign div_zero = dz_reg;
  assign result   = result_reg;
  assign flags    = flags_reg;

endmodule

// File: tb/tb_muldiv.sv
// Bench for muldiv: vector table, hand-built corner sequences, and random ops
// compared against an arithmetic reference model.
module tb_muldiv;

  logic        clk = 1'b0;
  logic        reset, start, op;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy, done, div_zero;
  logic [15:0] result;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_FAST_OVERFLOW_EN
  localparam int OVF_LAT = 1;
`else
  localparam int OVF_LAT = 17;
`endif

  muldiv dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .result(result), .flags(flags), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        o;
    logic [15:0] dd;
    logic [7:0]  ds;
    logic [15:0] res;
    logic [3:0]  fl;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic from the operation rules.
  function automatic void model(input logic o, input logic [15:0] dd, input logic [7:0] ds,
                                output logic [15:0] res, output logic [3:0] fl,
                                output logic dz, output int lat);
    int q, r, p;
    dz = 1'b0;
    if (o) begin
      p   = int'(dd[7:0]) * int'(ds);
      res = p[15:0];
      fl  = {p[15], 2'b00, p == 0};
      lat = 9;
    end else if (ds == 8'h00) begin
      res = dd; fl = 4'b1100; dz = 1'b1; lat = 1;
    end else begin
      q = int'(dd) / int'(ds);
      r = int'(dd) % int'(ds);
      if (q >= 256) begin
        res = dd; fl = 4'b0100; lat = OVF_LAT;
      end else begin
        res = {r[7:0], q[7:0]};
        fl  = {q[7], 2'b00, q == 0};
        lat = 17;
      end
    end
  endfunction

  task automatic issue(input bit now, input logic o, input logic [15:0] dd, input logic [7:0] ds);
    if (!now) @(negedge clk);
    start = 1'b1; op = o; dividend = dd; divisor = ds;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 1'($urandom); dividend = 16'($urandom); divisor = 8'($urandom);
  endtask

  task automatic wait_done(output int lat, output int busy_cyc, output logic [15:0] r,
                           output logic [3:0] f, output logic dz);
    bit got = 1'b0;
    lat = 0; busy_cyc = 0; r = 16'h0; f = 4'h0; dz = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (done) begin
        got = 1'b1;
        r = result; f = flags; dz = div_zero;
        chk("busy_at_done", 32'(busy), 32'd0);
      end else if (busy) begin
        busy_cyc++;
      end
    end
    if (!got) lat = -1;
  endtask

  task automatic run_check(input bit now, input logic o, input logic [15:0] dd, input logic [7:0] ds,
                           input logic [15:0] eres, input logic [3:0] efl, input logic edz,
                           input int elat);
    int lat, bc;
    logic [15:0] r;
    logic [3:0] f;
    logic dz;
    issue(now, o, dd, ds);
    wait_done(lat, bc, r, f, dz);
    $display("txn op=%0d dd=%h ds=%h result=%h flags=%b dz=%b lat=%0d busy=%0d",
             o, dd, ds, r, f, dz, lat, bc);
    chk("latency", 32'(lat), 32'(elat));
    chk("result", 32'(r), 32'(eres));
    chk("flags", 32'(f), 32'(efl));
    chk("div_zero", 32'(dz), 32'(edz));
    chk("busy_cycles", 32'(bc), 32'(elat - 1));
  endtask

  task automatic run_model(input bit now, input logic o, input logic [15:0] dd, input logic [7:0] ds);
    logic [15:0] er;
    logic [3:0] ef;
    logic ez;
    int el;
    model(o, dd, ds, er, ef, ez, el);
    run_check(now, o, dd, ds, er, ef, ez, el);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat, bc;
    logic [15:0] r;
    logic [3:0] f;
    logic dz, ro;
    logic [15:0] rdd;
    logic [7:0] rds;

    reset = 1'b1; start = 1'b0; op = 1'b0; dividend = 16'h0; divisor = 8'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    reset = 1'b0;

    vecs[0] = '{1'b0, 16'h1234, 8'h56, 16'h1036, 4'b0000, 1'b0, 17};
    vecs[1] = '{1'b0, 16'h1234, 8'h00, 16'h1234, 4'b1100, 1'b1, 1};
    vecs[2] = '{1'b0, 16'h5678, 8'h10, 16'h5678, 4'b0100, 1'b0, OVF_LAT};
    vecs[3] = '{1'b1, 16'hABFF, 8'hFF, 16'hFE01, 4'b1000, 1'b0, 9};
    vecs[4] = '{1'b0, 16'h00FF, 8'h0F, 16'h0011, 4'b0000, 1'b0, 17};
    vecs[5] = '{1'b0, 16'h0005, 8'h07, 16'h0500, 4'b0001, 1'b0, 17};
    vecs[6] = '{1'b0, 16'hFEFF, 8'hFF, 16'hFEFF, 4'b1000, 1'b0, 17};
    vecs[7] = '{1'b0, 16'hFF00, 8'hFF, 16'hFF00, 4'b0100, 1'b0, OVF_LAT};

    for (int i = 0; i < 8; i++) begin
      run_check(1'b0, vecs[i].o, vecs[i].dd, vecs[i].ds, vecs[i].res, vecs[i].fl,
                vecs[i].dz, vecs[i].lat);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("dz_one_cycle", 32'(div_zero), 32'd0);
    end

    // Back-to-back: second MUL launched while the first is in FIN.
    run_check(1'b0, 1'b1, 16'h00FF, 8'hFF, 16'hFE01, 4'b1000, 1'b0, 9);
    run_check(1'b1, 1'b1, 16'h1200, 8'h37, 16'h0000, 4'b0001, 1'b0, 9);

    // start pulsed during RUN must be ignored.
    issue(1'b0, 1'b0, 16'h1234, 8'h56);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 1'b0; dividend = 16'h00FF; divisor = 8'h0F;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc, r, f, dz);
    $display("txn ignored-start result=%h flags=%b", r, f);
    chk("run_start_result", 32'(r), 32'h1036);
    chk("run_start_flags", 32'(f), 32'h0);
    count_dones(25, n);
    chk("run_start_extra_done", 32'(n), 32'd0);

    // Reset in the middle of a DIV.
    issue(1'b0, 1'b0, 16'h1234, 8'h56);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'h0);
    chk("abort_flags", 32'(flags), 32'h0);
    chk("abort_dz", 32'(div_zero), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    count_dones(25, n);
    chk("abort_no_done", 32'(n), 32'd0);
    $display("txn reset-abort dones_after=%0d", n);
    run_model(1'b0, 1'b0, 16'h0F0F, 8'h33);

    // Randomised ops, some issued back-to-back from FIN.
    for (int i = 0; i < 60; i++) begin
      ro  = 1'($urandom);
      rdd = 16'($urandom);
      rds = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_model(1'($urandom_range(0, 3) == 0), ro, rdd, rds);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
